// File: rtl/ecc_pkg.sv
// Shared GF(2^7) / binary-curve definitions for the scalar multiplier and its point operators.
// Field polynomial x^7 + x + 1; curve y^2 + xy = x^3 + a*x^2 + b.
package ecc_pkg;

  localparam int unsigned COORD_W = 7;
  localparam int unsigned POINT_W = 14;
  localparam int unsigned PROD_W  = 2 * COORD_W - 1;

  localparam logic [POINT_W-1:0] POINT_INF  = 14'h0000;
  localparam logic [COORD_W-1:0] CURVE_A    = 7'd1;
  localparam logic [COORD_W-1:0] CURVE_B    = 7'd1;
  localparam logic [PROD_W-1:0]  FIELD_POLY = 13'h0083;

  typedef enum logic [2:0] {
    StIdle,
    StDblGo,
    StDblWait,
    StAddChk,
    StAddGo,
    StAddWait,
    StNext,
    StDone
  } state_e;

  // Points are packed as {y, x}.
  function automatic logic [COORD_W-1:0] get_x(input logic [POINT_W-1:0] pt);
    return pt[COORD_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] get_y(input logic [POINT_W-1:0] pt);
    return pt[POINT_W-1:COORD_W];
  endfunction

endpackage

// File: rtl/ec_scalar_mult_if.sv
// Request/response bundle of the scalar multiplier.
interface ec_scalar_mult_if
  import ecc_pkg::*;
#(
  parameter int unsigned K_WIDTH = 8
);

  logic               start;
  logic [K_WIDTH-1:0] scalar;
  logic [POINT_W-1:0] point;
  logic               busy;
  logic               done;
  logic [POINT_W-1:0] result;

  modport master (output start, scalar, point, input busy, done, result);
  modport slave  (input start, scalar, point, output busy, done, result);

endinterface

// File: rtl/Inverse.sv
// GF(2^7) inverse as a^(2^7 - 2); maps 0 to 0.
module Inverse
  import ecc_pkg::*;
(
  input  logic [COORD_W-1:0] a,
  output logic [COORD_W-1:0] inv
);

  // r<n> holds a^(2^n - 1); one square-and-multiply per step.
  logic [COORD_W-1:0] s1, s2, s3, s4, s5;
  logic [COORD_W-1:0] r2, r3, r4, r5, r6;

  Squarer     u_sq1  (.a(a),  .sq(s1));
  Mastrovito7 u_mul1 (.a(s1), .b(a), .p(r2));
  Squarer     u_sq2  (.a(r2), .sq(s2));
  Mastrovito7 u_mul2 (.a(s2), .b(a), .p(r3));
  Squarer     u_sq3  (.a(r3), .sq(s3));
  Mastrovito7 u_mul3 (.a(s3), .b(a), .p(r4));
  Squarer     u_sq4  (.a(r4), .sq(s4));
  Mastrovito7 u_mul4 (.a(s4), .b(a), .p(r5));
  Squarer     u_sq5  (.a(r5), .sq(s5));
  Mastrovito7 u_mul5 (.a(s5), .b(a), .p(r6));
  Squarer     u_sq6  (.a(r6), .sq(inv));

endmodule

// File: rtl/Mastrovito7.sv
// GF(2^7) multiplier: carry-less product followed by reduction modulo x^7 + x + 1.
module Mastrovito7
  import ecc_pkg::*;
(
  input  logic [COORD_W-1:0] a,
  input  logic [COORD_W-1:0] b,
  output logic [COORD_W-1:0] p
);

  logic [PROD_W-1:0] prod;

  always_comb begin
    prod = '0;
    for (int i = 0; i < COORD_W; i++) begin
      if (b[i]) prod = prod ^ (PROD_W'(a) << i);
    end
    for (int i = PROD_W - 1; i >= COORD_W; i--) begin
      if (prod[i]) prod = prod ^ (FIELD_POLY << (i - COORD_W));
    end
    p = prod[COORD_W-1:0];
  end

endmodule

// File: rtl/PointDouble.sv
// Point doubling on the binary curve; operand latched on load, sum settles before OP_CYCLES.
module PointDouble
  import ecc_pkg::*;
(
  input  logic               clk,
  input  logic               load,
  input  logic [POINT_W-1:0] p,
  output logic [POINT_W-1:0] sum
);

  logic [POINT_W-1:0] op_q;
  logic [COORD_W-1:0] x, y, x_inv, y_over_x, lam, lam_sq, x_sq, x3, t, y3;

  always_ff @(posedge clk) begin
    if (load) op_q <= p;
  end

  assign x = get_x(op_q);
  assign y = get_y(op_q);

  Inverse     u_inv  (.a(x), .inv(x_inv));
  Mastrovito7 u_mul0 (.a(y), .b(x_inv), .p(y_over_x));
  assign lam = x ^ y_over_x;
  Squarer     u_sq0  (.a(lam), .sq(lam_sq));
  assign x3 = lam_sq ^ lam ^ CURVE_A;
  Squarer     u_sq1  (.a(x), .sq(x_sq));
  Mastrovito7 u_mul1 (.a(lam ^ 7'd1), .b(x3), .p(t));
  assign y3 = x_sq ^ t;

  // Points with x = 0 (infinity and the order-2 point) double to infinity.
  assign sum = (x == '0) ? POINT_INF : {y3, x3};

endmodule

// File: rtl/Squarer.sv
// GF(2^7) squarer: squaring is linear, so spread the bits and reduce.
module Squarer
  import ecc_pkg::*;
(
  input  logic [COORD_W-1:0] a,
  output logic [COORD_W-1:0] sq
);

  logic [PROD_W-1:0] wide;

  always_comb begin
    wide = '0;
    for (int i = 0; i < COORD_W; i++) begin
      wide[2*i] = a[i];
    end
    for (int i = PROD_W - 1; i >= COORD_W; i--) begin
      if (wide[i]) wide = wide ^ (FIELD_POLY << (i - COORD_W));
    end
    sq = wide[COORD_W-1:0];
  end

endmodule

// File: rtl/ec_point_add.sv
// Chord addition for x1 != x2, same load/latency contract as PointDouble.
module ec_point_add
  import ecc_pkg::*;
(
  input  logic               clk,
  input  logic               load,
  input  logic [POINT_W-1:0] p1,
  input  logic [POINT_W-1:0] p2,
  output logic [POINT_W-1:0] sum
);

  logic [POINT_W-1:0] p1_q, p2_q;
  logic [COORD_W-1:0] x1, y1, dx, dy, dx_inv, lam, lam_sq, x3, t, y3;

  always_ff @(posedge clk) begin
    if (load) begin
      p1_q <= p1;
      p2_q <= p2;
    end
  end

  assign x1 = get_x(p1_q);
  assign y1 = get_y(p1_q);
  assign dx = x1 ^ get_x(p2_q);
  assign dy = y1 ^ get_y(p2_q);

  Inverse     u_inv  (.a(dx), .inv(dx_inv));
  Mastrovito7 u_mul0 (.a(dy), .b(dx_inv), .p(lam));
  Squarer     u_sq   (.a(lam), .sq(lam_sq));
  assign x3 = lam_sq ^ lam ^ dx ^ CURVE_A;
  Mastrovito7 u_mul1 (.a(lam), .b(x1 ^ x3), .p(t));
  assign y3 = t ^ x3 ^ y1;

  assign sum = {y3, x3};

endmodule

// File: rtl/ec_scalar_mult.sv
// Left-to-right double-and-add sequencer computing k*P with PointDouble and ec_point_add.
module ec_scalar_mult
  import ecc_pkg::*;
#(
  parameter int unsigned K_WIDTH   = 8,
  parameter int unsigned OP_CYCLES = 8
) (
  input logic              clk,
  input logic              reset,
  ec_scalar_mult_if.slave  bus
);

  localparam int unsigned IDX_W = (K_WIDTH > 1) ? $clog2(K_WIDTH) : 1;
  localparam int unsigned CNT_W = $clog2(OP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OP_CYCLES - 1);

  state_e             state_q, state_d;
  logic [POINT_W-1:0] acc_q, acc_d, p_q, p_d, result_q, result_d;
  logic [K_WIDTH-1:0] k_q, k_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               redbl_q, redbl_d;
  logic               dbl_load, add_load;
  logic [POINT_W-1:0] dbl_sum, add_sum;

  PointDouble u_dbl (
    .clk (clk),
    .load(dbl_load),
    .p   (acc_q),
    .sum (dbl_sum)
  );

  ec_point_add u_add (
    .clk (clk),
    .load(add_load),
    .p1  (acc_q),
    .p2  (p_q),
    .sum (add_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      acc_q    <= POINT_INF;
      p_q      <= POINT_INF;
      k_q      <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      redbl_q  <= 1'b0;
      result_q <= POINT_INF;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      k_q      <= k_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      redbl_q  <= redbl_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    p_d      = p_q;
    k_d      = k_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    redbl_d  = redbl_q;
    result_d = result_q;
    dbl_load = 1'b0;
    add_load = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          k_d     = bus.scalar;
          p_d     = bus.point;
          acc_d   = POINT_INF;
          idx_d   = IDX_W'(K_WIDTH - 1);
          redbl_d = 1'b0;
          state_d = StDblGo;
        end
      end
      StDblGo: begin
        dbl_load = 1'b1;
        cnt_d    = '0;
        state_d  = StDblWait;
      end
      StDblWait: begin
        if (cnt_q == CNT_LAST) begin
          acc_d = dbl_sum;
          // A re-double stands in for acc + P, so the bit's add is already done.
          if (redbl_q) begin
            redbl_d = 1'b0;
            state_d = StNext;
          end else if (k_q[idx_q]) begin
            state_d = StAddChk;
          end else begin
            state_d = StNext;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAddChk: begin
        state_d = StNext;
        if (p_q != POINT_INF) begin
          if (acc_q == POINT_INF) begin
            acc_d = p_q;
          end else if (get_x(acc_q) == get_x(p_q)) begin
            if (get_y(acc_q) == get_y(p_q)) begin
              redbl_d = 1'b1;
              state_d = StDblGo;
            end else begin
              acc_d = POINT_INF;
            end
          end else begin
            state_d = StAddGo;
          end
        end
      end
      StAddGo: begin
        add_load = 1'b1;
        cnt_d    = '0;
        state_d  = StAddWait;
      end
      StAddWait: begin
        if (cnt_q == CNT_LAST) begin
          acc_d   = add_sum;
          state_d = StNext;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StNext: begin
        if (idx_q == '0) begin
          result_d = acc_q;
          state_d  = StDone;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = StDblGo;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus.busy   = (state_q != StIdle);
  assign bus.done   = (state_q == StDone);
  assign bus.result = result_q;

endmodule
